pipe_flow_ctrl: RTL
===================

Name: pipe_flow_ctrl

Overview:
Central handshake generator for the 5-stage F/D/E/M/W pipeline. It drives the valid/ready pairs that the inter-stage buffers consume, and a buffer loads on valid_X & ready_Y. It tracks a live bit per stage register and resolves load-use stalls, multi-cycle M-extension stalls, memory back-pressure, redirect flushes and ebreak halt. Downstream logic gates RegWrite, MemWrite and commit with the exported live bits.

Parameters:
MDU_LAT, 4, extra cycles an E-stage mul/div occupies E (0 = no stall)
CNT_W, 32, width of perf counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_ok  in  1  instruction for PC is available this cycle
reg_ren_D  in  1  D instr reads rs1/rs2
Rs1_D  in  5  D source 1
Rs2_D  in  5  D source 2
MemRead_E  in  1  E instr is a load
RegWrite_E  in  1  E instr writes Rd
Rd_E  in  5  E destination
mdu_E  in  1  E instr is mul/div
redirect_E  in  1  E resolved mispredict/jump (PC must change)
mem_busy_M  in  1  data memory not done for M instr
ebreak_W  in  1  W instr is ebreak
valid_F, ready_D, valid_D, ready_E, valid_E, ready_M, valid_M, ready_W  out  1 each  buffer handshakes
pc_en  out  1  PC register update enable
flush  out  1  redirect accepted; PC loads target
live_D, live_E, live_M, live_W  out  1 each  stage holds a real instruction
halted  out  1  ebreak retired, core frozen
cycle_cnt  out  CNT_W  cycles since reset while RUN
instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_n=0): all live_* 0, mdu counter 0, state RUN, counters 0, halted 0. Outputs are combinational from this state.
- stall_M = live_M & mem_busy_M.
- stall_mdu = live_E & mdu_E & (cnt != MDU_LAT). cnt is 0..MDU_LAT. It increments when stall_mdu & ~stall_M, and clears when E advances.
- stall_E = stall_mdu | stall_M.
- hazard_D = live_D & live_E & MemRead_E & RegWrite_E & (Rd_E!=0) & reg_ren_D & (Rd_E==Rs1_D | Rd_E==Rs2_D).
- stall_D = hazard_D | stall_E.
- flush = live_E & redirect_E & ~stall_E.
- RUN outputs: valid_F=fetch_ok; ready_D=~stall_D; valid_D=~stall_D; ready_E=~stall_E; valid_E=~stall_mdu; ready_M=~stall_M; valid_M=1; ready_W=1; pc_en = flush | (fetch_ok & ~stall_D).
- Live-bit next state:
  - live_D: if flush then 0; else if ~stall_D then fetch_ok; else hold.
  - live_E: if stall_E then hold; else if flush or hazard_D then 0; else live_D.
  - live_M: if stall_M then hold; else live_E & ~stall_mdu.
  - live_W: live_M & ~stall_M.
- A redirecting E instr itself proceeds to M. Only younger D/E contents die.
- Dead stage registers may hold stale or duplicate data. Consumers must gate side effects with live_*.
- Timing: load-use costs 1 bubble. An mdu instr stays in E for MDU_LAT+1 cycles. Flush costs 2 dead slots (D and E).
- State machine RUN→HALT when live_W & ebreak_W. HALT is sticky until reset.
  - In HALT: halted=1; all valid_*/ready_* except ready_W are 0; pc_en=0; flush=0; live bits and counters frozen.
- cycle_cnt increments every RUN cycle. instret_cnt increments when live_W in RUN, including the ebreak itself. Both wrap modulo 2^CNT_W.
- Simultaneous events:
  - stall_M dominates everything (freezes M and upstream).
  - mdu stall blocks redirect from the same E instr until it advances.
  - hazard_D with flush: flush wins and D is killed.
- Reset mid-stall or mid-mdu: the counter and live bits clear immediately.

Test Plan:
- Straight-line: fetch_ok=1, no hazards, 10 cycles → live_W first high at cycle 4; instret_cnt=6 after cycle 10; ready_*/valid_* all 1.
- Load-use: E = lw x5 (MemRead_E=1, RegWrite_E=1, Rd_E=5), D reads Rs1_D=5 → ready_D=0 and pc_en=0 for 1 cycle; next-cycle live_E=0 then D proceeds. With Rd_E=0 → no stall.
- MDU: mdu_E=1, MDU_LAT=4 → valid_E=0 for 4 cycles, E holds 5 cycles total; live_M=0 during the stall. Repeat with MDU_LAT=0 → no stall.
- Redirect: redirect_E=1 with live_E=1 → flush=1, pc_en=1; next cycle live_D=0, live_E=0; redirecting instr appears live_M. Same with mem_busy_M=1 → flush=0 until M frees.
- Memory back-pressure: mem_busy_M=1 for 3 cycles with live_M=1 → ready_M/ready_E/ready_D=0, live_W=0 for 3 cycles, no instr lost; then resume.
- Halt + reset: ebreak reaches W → halted=1 next cycle; cycle_cnt frozen; instret_cnt includes ebreak. Assert rst_n=0 mid-HALT → all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/pipe_flow_ctrl.sv
// Handshake and liveness controller for a 5-stage F/D/E/M/W pipeline.
// Resolves load-use hazards, multi-cycle mul/div occupancy of E, data
// memory back-pressure, redirect flushes and the ebreak halt, and keeps a
// live bit per stage register so consumers can gate side effects.
module pipe_flow_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_ok,
  input  logic             reg_ren_D,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             MemRead_E,
  input  logic             RegWrite_E,
  input  logic [4:0]       Rd_E,
  input  logic             mdu_E,
  input  logic             redirect_E,
  input  logic             mem_busy_M,
  input  logic             ebreak_W,
  output logic             valid_F,
  output logic             ready_D,
  output logic             valid_D,
  output logic             ready_E,
  output logic             valid_E,
  output logic             ready_M,
  output logic             valid_M,
  output logic             ready_W,
  output logic             pc_en,
  output logic             flush,
  output logic             live_D,
  output logic             live_E,
  output logic             live_M,
  output logic             live_W,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Counter wide enough to hold 0..MDU_LAT; one bit minimum when MDU_LAT is 0.
  localparam int MW = (MDU_LAT > 0) ? $clog2(MDU_LAT + 1) : 1;
  localparam logic [MW-1:0] MDU_MAX = MW'(MDU_LAT);

  typedef enum logic {RUN, HALT} state_t;

  state_t state, state_nxt;

  logic          run;
  logic          stall_m, stall_mdu, stall_e, hazard_d, stall_d, redirect_ok;
  logic          rd_match;
  logic [MW-1:0] mdu_cnt, mdu_cnt_nxt;
  logic          live_d_nxt, live_e_nxt, live_m_nxt, live_w_nxt;

  assign run = (state == RUN);

  // Stall and hazard conditions derived from the current stage contents.
  always_comb begin
    rd_match    = (Rd_E == Rs1_D) || (Rd_E == Rs2_D);
    stall_m     = live_M & mem_busy_M;
    stall_mdu   = live_E & mdu_E & (mdu_cnt != MDU_MAX);
    stall_e     = stall_mdu | stall_m;
    hazard_d    = live_D & live_E & MemRead_E & RegWrite_E & (Rd_E != 5'd0)
                  & reg_ren_D & rd_match;
    stall_d     = hazard_d | stall_e;
    // A redirect is only taken once its instruction is free to leave E.
    redirect_ok = live_E & redirect_E & ~stall_e;
  end

  // Run/halt state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; HALT freezes every hand-off except W.
  always_comb begin
    state_nxt = state;
    valid_F   = 1'b0;
    ready_D   = 1'b0;
    valid_D   = 1'b0;
    ready_E   = 1'b0;
    valid_E   = 1'b0;
    ready_M   = 1'b0;
    valid_M   = 1'b0;
    ready_W   = 1'b1;
    pc_en     = 1'b0;
    flush     = 1'b0;
    halted    = 1'b0;
    case (state)
      RUN: begin
        valid_F = fetch_ok;
        ready_D = ~stall_d;
        valid_D = ~stall_d;
        ready_E = ~stall_e;
        valid_E = ~stall_mdu;
        ready_M = ~stall_m;
        valid_M = 1'b1;
        flush   = redirect_ok;
        pc_en   = redirect_ok | (fetch_ok & ~stall_d);
        if (live_W && ebreak_W) state_nxt = HALT;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Live-bit and mul/div occupancy next state; everything holds in HALT.
  always_comb begin
    live_d_nxt  = live_D;
    live_e_nxt  = live_E;
    live_m_nxt  = live_M;
    live_w_nxt  = live_W;
    mdu_cnt_nxt = mdu_cnt;
    if (run) begin
      // Flush kills the younger D contents even when D would otherwise stall.
      if (redirect_ok)   live_d_nxt = 1'b0;
      else if (!stall_d) live_d_nxt = fetch_ok;
      // E takes a bubble on a load-use hazard or behind a redirect.
      if (!stall_e)      live_e_nxt = (redirect_ok | hazard_d) ? 1'b0 : live_D;
      // A mul/div still occupying E hands a bubble to M.
      if (!stall_m)      live_m_nxt = live_E & ~stall_mdu;
      live_w_nxt = live_M & ~stall_m;
      // Occupancy counts only while memory is not also holding E.
      if (!stall_e)                 mdu_cnt_nxt = '0;
      else if (stall_mdu && !stall_m) mdu_cnt_nxt = mdu_cnt + MW'(1);
    end
  end

  // Stage live bits and mul/div occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_D  <= 1'b0;
      live_E  <= 1'b0;
      live_M  <= 1'b0;
      live_W  <= 1'b0;
      mdu_cnt <= '0;
    end else begin
      live_D  <= live_d_nxt;
      live_E  <= live_e_nxt;
      live_M  <= live_m_nxt;
      live_W  <= live_w_nxt;
      mdu_cnt <= mdu_cnt_nxt;
    end
  end

  // Performance counters; retirement includes the ebreak that halts the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (run) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (live_W) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule
